// File: rtl/kuuga_pkg.sv
// Shared types and widths for the kuuga BRAM responder slice.
package kuuga_pkg;

    localparam int BRAM_ADDR_W = 16;
    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_WE_W   = 4;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } resp_state_e;

    // Which source drives the registered read data port.
    typedef enum logic [1:0] {
        OUT_RST = 2'd0,
        OUT_OOR = 2'd1,
        OUT_MEM = 2'd2
    } out_sel_e;

    function automatic logic [BRAM_DATA_W-1:0] byte_merge(
        input logic [BRAM_DATA_W-1:0] old_dat,
        input logic [BRAM_DATA_W-1:0] new_dat,
        input logic [BRAM_WE_W-1:0]   be
    );
        logic [BRAM_DATA_W-1:0] res;
        res = old_dat;
        for (int i = 0; i < BRAM_WE_W; i++) begin
            if (be[i]) res[8*i +: 8] = new_dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/kuuga_bram_resp_array.sv
// Byte-enabled single-port word array with read-first registered read.
// Latency: 1 cycle read; no backpressure (accepts an access every cycle).
module kuuga_bram_resp_array
    import kuuga_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic [AW-1:0]          addr,
    input  logic                   wr_en,
    input  logic [BRAM_WE_W-1:0]   wr_be,
    input  logic [BRAM_DATA_W-1:0] wr_dat,
    input  logic                   rd_en,
    output logic [BRAM_DATA_W-1:0] rd_dat
);

    logic [BRAM_DATA_W-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-cycle read returns the old word.
    always_ff @(posedge clk) begin
        if (rd_en) rd_dat <= mem[addr];
        if (wr_en) mem[addr] <= byte_merge(mem[addr], wr_dat, wr_be);
    end

endmodule

// File: rtl/kuuga_bram_responder.sv
// BRAM responder: preload stream then single-port byte-enabled memory; stats under KUUGA_BRAM_RESP_STATS_EN.
// Latency: read data registered, 1 cycle. Backpressure: load_ready only in S_LOAD; BRAM side never stalls.
module kuuga_bram_responder
    import kuuga_pkg::*;
#(
    parameter int               DEPTH       = 1024,
    parameter logic [31:0]      RESET_VALUE = 32'hEEEEEEEE,
    parameter logic [31:0]      OOR_VALUE   = 32'hDEADBEEF,
    parameter bit               SKIP_LOAD   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BRAM_ADDR_W-1:0] bram_addr_a,
    input  logic                   bram_en_a,
    input  logic [BRAM_WE_W-1:0]   bram_we_a,
    input  logic [BRAM_DATA_W-1:0] bram_wrdata_a,
    input  logic                   bram_rst_a,
    output logic [BRAM_DATA_W-1:0] bram_rddata_a,
    output logic                   bram_ready,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [BRAM_DATA_W-1:0] load_data,
    input  logic                   load_last,
    output logic                   err_oor,
    output logic [31:0]            stat_reads,
    output logic [31:0]            stat_writes
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_state_e state_q, state_d;
    out_sel_e    out_sel_q, out_sel_d;
    logic [AW-1:0] ptr_q;

    logic [BRAM_ADDR_W-3:0] word_idx;
    logic                   oor;
    logic                   unused_addr_lsb;
    logic                   load_beat, run_acc, err_set;
    logic [AW-1:0]          arr_addr;
    logic                   arr_wr_en, arr_rd_en;
    logic [BRAM_WE_W-1:0]   arr_be;
    logic [BRAM_DATA_W-1:0] arr_wr_dat, arr_rd_dat;

    assign word_idx        = bram_addr_a[BRAM_ADDR_W-1:2];
    assign oor             = 32'(word_idx) >= 32'(DEPTH);
    assign unused_addr_lsb = ^bram_addr_a[1:0];

    always_comb begin
        state_d    = state_q;
        out_sel_d  = out_sel_q;
        load_ready = 1'b0;
        bram_ready = 1'b0;
        load_beat  = 1'b0;
        run_acc    = 1'b0;
        err_set    = 1'b0;
        arr_addr   = word_idx[AW-1:0];
        arr_wr_en  = 1'b0;
        arr_rd_en  = 1'b0;
        arr_be     = bram_we_a;
        arr_wr_dat = bram_wrdata_a;
        case (state_q)
            S_LOAD: begin
                load_ready = 1'b1;
                out_sel_d  = OUT_RST;
                arr_addr   = ptr_q;
                arr_be     = '1;
                arr_wr_dat = load_data;
                if (load_valid) begin
                    load_beat = 1'b1;
                    arr_wr_en = 1'b1;
                    if (load_last || ptr_q == AW'(DEPTH - 1)) state_d = S_RUN;
                end
            end
            S_RUN: begin
                bram_ready = 1'b1;
                if (bram_en_a) begin
                    run_acc = 1'b1;
                    err_set = oor;
                    // Out-of-range accesses never touch the array.
                    arr_rd_en = !oor;
                    arr_wr_en = !oor && (bram_we_a != '0);
                end
                if (bram_rst_a)     out_sel_d = OUT_RST;
                else if (bram_en_a) out_sel_d = oor ? OUT_OOR : OUT_MEM;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SKIP_LOAD ? S_RUN : S_LOAD;
            out_sel_q <= OUT_RST;
            ptr_q     <= '0;
            err_oor   <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_sel_q <= out_sel_d;
            if (load_beat) ptr_q <= ptr_q + 1'b1;
            if (err_set)   err_oor <= 1'b1;
        end
    end

    always_comb begin
        case (out_sel_q)
            OUT_OOR: bram_rddata_a = OOR_VALUE;
            OUT_MEM: bram_rddata_a = arr_rd_dat;
            default: bram_rddata_a = RESET_VALUE;
        endcase
    end

    kuuga_bram_resp_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk    (clk),
        .addr   (arr_addr),
        .wr_en  (arr_wr_en),
        .wr_be  (arr_be),
        .wr_dat (arr_wr_dat),
        .rd_en  (arr_rd_en),
        .rd_dat (arr_rd_dat)
    );

`ifdef KUUGA_BRAM_RESP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else if (run_acc) begin
            if (bram_we_a == '0) begin
                if (stat_reads != 32'hFFFFFFFF) stat_reads <= stat_reads + 1'b1;
            end else begin
                if (stat_writes != 32'hFFFFFFFF) stat_writes <= stat_writes + 1'b1;
            end
        end
    end
`else
    logic unused_run_acc;
    assign unused_run_acc = run_acc;
    assign stat_reads     = 32'h0;
    assign stat_writes    = 32'h0;
`endif

endmodule

// File: tb/tb_kuuga_bram_responder.sv
// Randomised self-checking bench for kuuga_bram_responder against a word-array reference model.
module tb_kuuga_bram_responder;

    localparam int          DEPTH   = 1024;
    localparam logic [31:0] RESET_V = 32'hEEEEEEEE;
    localparam logic [31:0] OOR_V   = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bram_addr_a;
    logic        bram_en_a;
    logic [3:0]  bram_we_a;
    logic [31:0] bram_wrdata_a;
    logic        bram_rst_a;
    logic [31:0] bram_rddata_a;
    logic        bram_ready;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        err_oor;
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;

    always #5 clk = ~clk;

    kuuga_bram_responder dut (
        .clk           (clk),
        .reset         (reset),
        .bram_addr_a   (bram_addr_a),
        .bram_en_a     (bram_en_a),
        .bram_we_a     (bram_we_a),
        .bram_wrdata_a (bram_wrdata_a),
        .bram_rst_a    (bram_rst_a),
        .bram_rddata_a (bram_rddata_a),
        .bram_ready    (bram_ready),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .err_oor       (err_oor),
        .stat_reads    (stat_reads),
        .stat_writes   (stat_writes)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_reads, exp_writes;
    int          m_ptr;
    bit          m_loading;

    function automatic logic [31:0] exp_stat(input int n);
`ifdef KUUGA_BRAM_RESP_STATS_EN
        return 32'(n);
`else
        return 32'h0 + 32'(n) * 32'h0;
`endif
    endfunction

    task automatic idle_inputs();
        bram_addr_a   = '0;
        bram_en_a     = 1'b0;
        bram_we_a     = '0;
        bram_wrdata_a = '0;
        bram_rst_a    = 1'b0;
        load_valid    = 1'b0;
        load_data     = '0;
        load_last     = 1'b0;
    endtask

    task automatic assert_reset();
        @(posedge clk); #1;
        idle_inputs();
        reset      = 1'b1;
        m_ptr      = 0;
        m_loading  = 1'b1;
        exp_rd     = RESET_V;
        exp_err    = 1'b0;
        exp_reads  = 0;
        exp_writes = 0;
        #2;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load_beat(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk); #1;
        if (m_loading) begin
            mem_m[m_ptr] = d;
            if (last || m_ptr == DEPTH - 1) m_loading = 1'b0;
            m_ptr++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic access(input logic en, input logic [3:0] we, input logic [15:0] addr,
                          input logic [31:0] wd, input logic rst_a);
        int idx;
        idx           = int'(addr) / 4;
        bram_en_a     = en;
        bram_we_a     = we;
        bram_addr_a   = addr;
        bram_wrdata_a = wd;
        bram_rst_a    = rst_a;
        if (!m_loading) begin
            if (rst_a)   exp_rd = RESET_V;
            else if (en) exp_rd = (idx >= DEPTH) ? OOR_V : mem_m[idx];
            if (en) begin
                if (idx >= DEPTH) exp_err = 1'b1;
                else for (int b = 0; b < 4; b++)
                    if (we[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
                if (we == 4'h0) exp_reads++;
                else            exp_writes++;
            end
        end
        @(posedge clk); #1;
        bram_en_a  = 1'b0;
        bram_we_a  = '0;
        bram_rst_a = 1'b0;
    endtask

    task automatic test_reset();
        assert_reset();
        checks += 5;
        if (bram_rddata_a !== RESET_V) begin failures++; $display("FAIL reset_rddata: got %h expected %h", bram_rddata_a, RESET_V); end
        if (bram_ready !== 1'b0) begin failures++; $display("FAIL reset_bram_ready: got %b expected 0", bram_ready); end
        if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
        if (err_oor !== 1'b0) begin failures++; $display("FAIL reset_err_oor: got %b expected 0", err_oor); end
        if (stat_reads !== 32'h0 || stat_writes !== 32'h0) begin
            failures++; $display("FAIL reset_stats: got %h/%h expected 0/0", stat_reads, stat_writes);
        end
        release_reset();
    endtask

    task automatic test_preload();
        load_beat(32'h11, 1'b0);
        load_beat(32'h22, 1'b0);
        checks++;
        if (bram_ready !== 1'b0) begin failures++; $display("FAIL preload_not_ready: got %b expected 0", bram_ready); end
        load_beat(32'h33, 1'b1);
        checks += 3;
        if (bram_ready !== 1'b1) begin failures++; $display("FAIL preload_ready: got %b expected 1", bram_ready); end
        if (load_ready !== 1'b0) begin failures++; $display("FAIL preload_load_ready: got %b expected 0", load_ready); end
        if (bram_rddata_a !== RESET_V) begin failures++; $display("FAIL preload_rddata: got %h expected %h", bram_rddata_a, RESET_V); end
        access(1'b1, 4'h0, 16'h0008, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL preload_read8: got %h expected %h", bram_rddata_a, exp_rd); end
    endtask

    task automatic test_byte_write();
        access(1'b1, 4'b0011, 16'h0004, 32'hAABBCCDD, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL bytewr_read_first: got %h expected %h", bram_rddata_a, exp_rd); end
        access(1'b1, 4'h0, 16'h0004, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL bytewr_reread: got %h expected %h", bram_rddata_a, exp_rd); end
        access(1'b0, 4'h0, 16'h0008, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL hold_no_en: got %h expected %h", bram_rddata_a, exp_rd); end
    endtask

    task automatic test_oor();
        access(1'b1, 4'hF, 16'h1000, 32'h12345678, 1'b0);
        checks += 2;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL oor_rddata: got %h expected %h", bram_rddata_a, exp_rd); end
        if (err_oor !== exp_err) begin failures++; $display("FAIL oor_err: got %b expected %b", err_oor, exp_err); end
        access(1'b0, 4'h0, 16'h0000, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL oor_hold: got %h expected %h", bram_rddata_a, exp_rd); end
        access(1'b1, 4'h0, 16'h0000, 32'h0, 1'b0);
        checks += 2;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL oor_mem_unchanged: got %h expected %h", bram_rddata_a, exp_rd); end
        if (err_oor !== exp_err) begin failures++; $display("FAIL oor_sticky: got %b expected %b", err_oor, exp_err); end
        access(1'b1, 4'h0, 16'hFFFF, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL oor_top_addr: got %h expected %h", bram_rddata_a, exp_rd); end
        access(1'b1, 4'h0, 16'h0FFD, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL last_word_lsb_ignored: got %h expected %h", bram_rddata_a, exp_rd); end
    endtask

    task automatic test_rst_a();
        access(1'b1, 4'hF, 16'h0000, 32'h5, 1'b1);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL rst_a_rddata: got %h expected %h", bram_rddata_a, exp_rd); end
        access(1'b1, 4'h0, 16'h0000, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL rst_a_write_commits: got %h expected %h", bram_rddata_a, exp_rd); end
    endtask

    task automatic test_reset_midload();
        assert_reset();
        release_reset();
        load_beat(32'hA1, 1'b0);
        load_beat(32'hB2, 1'b0);
        assert_reset();
        checks += 3;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL midload_load_ready: got %b expected 1", load_ready); end
        if (bram_ready !== 1'b0) begin failures++; $display("FAIL midload_bram_ready: got %b expected 0", bram_ready); end
        if (bram_rddata_a !== RESET_V) begin failures++; $display("FAIL midload_rddata: got %h expected %h", bram_rddata_a, RESET_V); end
        release_reset();
        // BRAM-side write during load must be ignored
        bram_en_a = 1'b1; bram_we_a = 4'hF; bram_addr_a = 16'h0008; bram_wrdata_a = 32'hBAD0BAD0;
        load_beat(32'hC3, 1'b0);
        bram_en_a = 1'b0; bram_we_a = 4'h0;
        checks += 2;
        if (bram_ready !== 1'b0) begin failures++; $display("FAIL midload_still_loading: got %b expected 0", bram_ready); end
        if (bram_rddata_a !== RESET_V) begin failures++; $display("FAIL load_ignores_en: got %h expected %h", bram_rddata_a, RESET_V); end
        load_beat(32'hD4, 1'b1);
        access(1'b1, 4'h0, 16'h0000, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL reload_word0: got %h expected %h", bram_rddata_a, exp_rd); end
        access(1'b1, 4'h0, 16'h0008, 32'h0, 1'b0);
        checks++;
        if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL retained_word2: got %h expected %h", bram_rddata_a, exp_rd); end
    endtask

    task automatic test_stats();
        assert_reset();
        release_reset();
        load_beat(32'h77, 1'b1);
        for (int i = 0; i < 7; i++) begin
            access(1'b1, 4'h0, 16'(4 * $urandom_range(0, 3)), 32'h0, 1'b0);
            access(1'b0, 4'hF, 16'h0000, 32'h0, 1'b0);
        end
        access(1'b1, 4'h1, 16'h0010, 32'h01020304, 1'b0);
        access(1'b1, 4'hF, 16'h0014, 32'h05060708, 1'b0);
        access(1'b1, 4'h8, 16'h2000, 32'h090A0B0C, 1'b0);
        checks += 2;
        if (stat_reads !== exp_stat(exp_reads)) begin failures++; $display("FAIL stat_reads: got %0d expected %0d", stat_reads, exp_stat(exp_reads)); end
        if (stat_writes !== exp_stat(exp_writes)) begin failures++; $display("FAIL stat_writes: got %0d expected %0d", stat_writes, exp_stat(exp_writes)); end
    endtask

    task automatic test_random();
        int beats;
        assert_reset();
        release_reset();
        beats = 0;
        while (beats < DEPTH) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end else begin
                load_beat($urandom, 1'b0);
                beats++;
                if (beats == DEPTH - 1) begin
                    checks++;
                    if (bram_ready !== 1'b0) begin failures++; $display("FAIL full_load_early_ready: got %b expected 0", bram_ready); end
                end
            end
        end
        checks += 2;
        if (bram_ready !== 1'b1) begin failures++; $display("FAIL full_load_ready: got %b expected 1", bram_ready); end
        if (load_ready !== 1'b0) begin failures++; $display("FAIL full_load_load_ready: got %b expected 0", load_ready); end
        load_beat(32'hFFFF0000, 1'b1);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            logic [3:0]  w;
            a = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(4096, 65535)) : 16'($urandom_range(0, 4095));
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            access($urandom_range(0, 9) != 0, w, a, $urandom, $urandom_range(0, 19) == 0);
            checks += 2;
            if (bram_rddata_a !== exp_rd) begin failures++; $display("FAIL rand_rddata[%0d]: got %h expected %h", i, bram_rddata_a, exp_rd); end
            if (err_oor !== exp_err) begin failures++; $display("FAIL rand_err[%0d]: got %b expected %b", i, err_oor, exp_err); end
        end
        checks += 2;
        if (stat_reads !== exp_stat(exp_reads)) begin failures++; $display("FAIL rand_stat_reads: got %0d expected %0d", stat_reads, exp_stat(exp_reads)); end
        if (stat_writes !== exp_stat(exp_writes)) begin failures++; $display("FAIL rand_stat_writes: got %0d expected %0d", stat_writes, exp_stat(exp_writes)); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_preload();
        test_byte_write();
        test_oor();
        test_rst_a();
        test_reset_midload();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
